// File: rtl/sram_mem_arbiter_pkg.sv
// Shared definitions for the SRAM-like request arbiter.
//   src_e   : source tag stored in the order FIFO (0 = fetch, 1 = data)
//   state_e : grant FSM states
//   SIZE_WORD    : access size driven for instruction fetches
//   STARVE_LIMIT : consecutive data accepts tolerated while a fetch waits
package sram_mem_arbiter_pkg;

   typedef enum logic {
      SRC_INST = 1'b0,
      SRC_DATA = 1'b1
   } src_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD_I = 2'd1,
      HOLD_D = 2'd2
   } state_e;

   localparam logic [2:0] SIZE_WORD    = 3'd2;
   localparam int         STARVE_LIMIT = 4;

endpackage

// File: rtl/sram_mem_arbiter_if.sv
// One SRAM-like channel: request fields flow master -> slave, the
// address/data handshakes and read data flow slave -> master.
//   master : issues requests (CPU side, or the arbiter towards memory)
//   slave  : accepts requests (the arbiter towards the CPU, or the memory)
interface sram_mem_arbiter_if;

   logic        req;
   logic        cache;
   logic        wr;
   logic [3:0]  wstrb;
   logic [2:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, cache, wr, wstrb, size, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, cache, wr, wstrb, size, addr, wdata,
      output addr_ok, data_ok, rdata
   );

endinterface

// File: rtl/sram_mem_arbiter_order_fifo.sv
// In-order source FIFO: remembers which requester issued each accepted
// transaction so responses can be routed back.
//   clk, resetn : clock, asynchronous active-low reset
//   push, din   : enqueue a source tag
//   pop         : dequeue the head (ignored when empty)
//   full, empty : occupancy flags derived from a registered count
//   head        : source tag of the oldest outstanding transaction
module sram_mem_arbiter_order_fifo
   import sram_mem_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic clk,
   input  logic resetn,
   input  logic push,
   input  src_e din,
   input  logic pop,
   output logic full,
   output logic empty,
   output src_e head
);

   src_e             slots [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             pop_en;
   logic             push_en;

   assign pop_en  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
   assign push_en = push && (!full || pop_en);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_en, pop_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array is not reset; count/pointers alone define which
   // slots are valid, so resetting it would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (push_en) slots[wr_ptr] <= din;
   end

   assign full  = (count == (PTR_W + 1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = slots[rd_ptr];

endmodule

// File: rtl/sram_mem_arbiter.sv
// Merges the CPU fetch and data SRAM-like channels onto one memory port.
// Data has priority, a grant is locked until the memory accepts it, and a
// fetch waiting behind STARVE_LIMIT data accepts wins the next choice.
// Responses return in order and are steered by the order FIFO head.
//   clk, resetn : clock, asynchronous active-low reset
//   inst        : fetch channel (slave side)
//   data        : data channel (slave side)
//   mem         : shared downstream channel (master side)
//   resp_err    : sticky, a response arrived with nothing outstanding
module sram_mem_arbiter
   import sram_mem_arbiter_pkg::*;
#(
   parameter int OUTSTANDING = 4,
   parameter int PTR_W       = $clog2(OUTSTANDING)
) (
   input  logic                 clk,
   input  logic                 resetn,
   sram_mem_arbiter_if.slave    inst,
   sram_mem_arbiter_if.slave    data,
   sram_mem_arbiter_if.master   mem,
   output logic                 resp_err
);

   state_e     state;
   state_e     state_nxt;
   src_e       grant;
   logic       grant_req;
   logic [2:0] starve_cnt;
   logic       fifo_full;
   logic       fifo_empty;
   src_e       fifo_head;
   logic       accept;
   logic       resp_valid;
   logic       unused_inst;

   // Fetches are read-only word accesses; their write-side fields are ignored.
   assign unused_inst = ^{inst.wr, inst.wstrb, inst.size, inst.wdata};

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // ---------------- FSM: output (grant selection) ----------------
   // NOTE: every signal written in always_comb gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      grant = SRC_DATA;
      case (state)
         HOLD_I: grant = SRC_INST;
         HOLD_D: grant = SRC_DATA;
         default: begin
            if (starve_cnt >= 3'(STARVE_LIMIT) && inst.req) grant = SRC_INST;
            else if (data.req)                              grant = SRC_DATA;
            else if (inst.req)                              grant = SRC_INST;
         end
      endcase
      grant_req = (grant == SRC_INST) ? inst.req : data.req;
   end

   // ---------------- FSM: next state ----------------
   // While the order FIFO is full nothing can be presented, so the state is frozen.
   always_comb begin
      state_nxt = state;
      if (!fifo_full) begin
         case (state)
            IDLE: begin
               if (grant_req && !mem.addr_ok)
                  state_nxt = (grant == SRC_INST) ? HOLD_I : HOLD_D;
            end
            HOLD_I, HOLD_D: begin
               // A dropped request is a protocol violation; release the lock.
               if (!grant_req || mem.addr_ok) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // ---------------- Downstream request mux ----------------
   assign mem.req   = resetn && grant_req && !fifo_full;
   assign mem.cache = (grant == SRC_INST) ? inst.cache : data.cache;
   assign mem.wr    = (grant == SRC_INST) ? 1'b0       : data.wr;
   assign mem.wstrb = (grant == SRC_INST) ? 4'h0       : data.wstrb;
   assign mem.size  = (grant == SRC_INST) ? SIZE_WORD  : data.size;
   assign mem.addr  = (grant == SRC_INST) ? inst.addr  : data.addr;
   assign mem.wdata = (grant == SRC_INST) ? 32'h0      : data.wdata;

   assign accept       = mem.req && mem.addr_ok;
   assign inst.addr_ok = accept && (grant == SRC_INST);
   assign data.addr_ok = accept && (grant == SRC_DATA);

   // ---------------- Response steering ----------------
   assign resp_valid   = resetn && mem.data_ok && !fifo_empty;
   assign inst.data_ok = resp_valid && (fifo_head == SRC_INST);
   assign data.data_ok = resp_valid && (fifo_head == SRC_DATA);
   assign inst.rdata   = mem.rdata;
   assign data.rdata   = mem.rdata;

   sram_mem_arbiter_order_fifo #(
      .DEPTH (OUTSTANDING),
      .PTR_W (PTR_W)
   ) u_order_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (accept),
      .din    (grant),
      .pop    (mem.data_ok),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .head   (fifo_head)
   );

   // Counts data accepts made while a fetch was waiting; any fetch accept,
   // or a data accept with no fetch waiting, ends the streak.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt <= '0;
      end else if (accept) begin
         if (grant == SRC_INST || !inst.req)          starve_cnt <= '0;
         else if (starve_cnt != 3'(STARVE_LIMIT))     starve_cnt <= starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                      resp_err <= 1'b0;
      else if (mem.data_ok && fifo_empty) resp_err <= 1'b1;
   end

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Self-checking bench for sram_mem_arbiter: directed scenarios followed by a
// randomized phase, all compared against a transaction-level reference model.
module tb_sram_mem_arbiter;
   import sram_mem_arbiter_pkg::*;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic resp_err;

   always #5 clk = ~clk;

   sram_mem_arbiter_if inst_if ();
   sram_mem_arbiter_if data_if ();
   sram_mem_arbiter_if mem_if ();

   sram_mem_arbiter #(.OUTSTANDING(4)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .inst     (inst_if),
      .data     (data_if),
      .mem      (mem_if),
      .resp_err (resp_err)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   int   lock;          // -1 none, 0 fetch, 1 data
   int   streak;
   bit   order_q[$];    // 0 = fetch, 1 = data
   logic m_resp_err;
   int   cyc;

   // memory responder state
   int   due[$];
   bit   auto_resp;
   bit   man_dok;
   int   aok_pct;
   int   lat_min;
   int   lat_max;
   bit   rand_rdata;
   int   resp_num;

   // per-step results and observations
   bit          acc_i;
   bit          acc_d;
   logic [4:0]  obs_seq;
   int          n_idok;
   logic [31:0] last_i_rdata;
   logic [31:0] last_d_rdata;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic drive_mem();
      bit dok;
      mem_if.addr_ok = ($urandom_range(99) < aok_pct);
      if (auto_resp) dok = (due.size() > 0) && (due[0] <= cyc);
      else           dok = man_dok;
      if (dok && due.size() > 0) void'(due.pop_front());
      mem_if.data_ok = dok;
      mem_if.rdata   = rand_rdata ? $urandom : 32'h1111_1111 * resp_num;
      if (dok) resp_num++;
   endtask

   // One clock cycle: predict, compare at the falling edge, advance the model.
   task automatic step();
      int cand;
      bit full;
      bit ereq;
      bit eacc;
      bit ei_dok;
      bit ed_dok;
      @(negedge clk);
      full = (order_q.size() >= 4);
      if (lock == 0 && inst_if.req)      cand = 0;
      else if (lock == 1 && data_if.req) cand = 1;
      else if (lock != -1)               cand = -1;
      else if (streak >= 4 && inst_if.req) cand = 0;
      else if (data_if.req)              cand = 1;
      else if (inst_if.req)              cand = 0;
      else                               cand = -1;

      ereq   = (cand != -1) && !full;
      eacc   = ereq && mem_if.addr_ok;
      ei_dok = mem_if.data_ok && order_q.size() > 0 && order_q[0] == 1'b0;
      ed_dok = mem_if.data_ok && order_q.size() > 0 && order_q[0] == 1'b1;

      check("mem_req",      mem_if.req,      ereq);
      check("inst_addr_ok", inst_if.addr_ok, eacc && cand == 0);
      check("data_addr_ok", data_if.addr_ok, eacc && cand == 1);
      check("inst_data_ok", inst_if.data_ok, ei_dok);
      check("data_data_ok", data_if.data_ok, ed_dok);
      check("resp_err",     resp_err,        m_resp_err);
      if (ereq && cand == 0) begin
         check("mem_addr_i",  mem_if.addr,  inst_if.addr);
         check("mem_cache_i", mem_if.cache, inst_if.cache);
         check("mem_wr_i",    mem_if.wr,    1'b0);
         check("mem_wstrb_i", mem_if.wstrb, 4'h0);
         check("mem_size_i",  mem_if.size,  3'd2);
      end
      if (ereq && cand == 1) begin
         check("mem_addr_d",  mem_if.addr,  data_if.addr);
         check("mem_cache_d", mem_if.cache, data_if.cache);
         check("mem_wr_d",    mem_if.wr,    data_if.wr);
         check("mem_wstrb_d", mem_if.wstrb, data_if.wstrb);
         check("mem_size_d",  mem_if.size,  data_if.size);
         if (data_if.wr) check("mem_wdata_d", mem_if.wdata, data_if.wdata);
      end
      if (ei_dok) check("inst_rdata", inst_if.rdata, mem_if.rdata);
      if (ed_dok) check("data_rdata", data_if.rdata, mem_if.rdata);

      // observations for scenario-level checks
      if (inst_if.addr_ok || data_if.addr_ok) obs_seq = {obs_seq[3:0], data_if.addr_ok};
      if (inst_if.data_ok) begin n_idok++; last_i_rdata = inst_if.rdata; end
      if (data_if.data_ok) last_d_rdata = data_if.rdata;

      acc_i = eacc && cand == 0;
      acc_d = eacc && cand == 1;
      if (!full) lock = (eacc || cand == -1) ? -1 : cand;
      if (acc_d) streak = inst_if.req ? ((streak < 4) ? streak + 1 : 4) : 0;
      if (acc_i) streak = 0;
      if (mem_if.data_ok) begin
         if (order_q.size() > 0) void'(order_q.pop_front());
         else                    m_resp_err = 1'b1;
      end
      if (eacc) begin
         order_q.push_back(cand == 1);
         due.push_back(cyc + $urandom_range(lat_max, lat_min));
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic cycle();
      drive_mem();
      step();
      if (acc_i) inst_if.req = 1'b0;
      if (acc_d) data_if.req = 1'b0;
   endtask

   task automatic drain(input int n);
      inst_if.req = 1'b0;
      data_if.req = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      lock = -1; streak = 0; m_resp_err = 1'b0; cyc = 0;
      auto_resp = 1'b1; man_dok = 1'b0; aok_pct = 100;
      lat_min = 2; lat_max = 2; rand_rdata = 1'b0; resp_num = 1;
      obs_seq = '0; n_idok = 0; last_i_rdata = '0; last_d_rdata = '0;
      inst_if.req = 1'b1; inst_if.cache = 1'b1; inst_if.addr = 32'hBFC0_0000;
      inst_if.wr = 1'b0; inst_if.wstrb = '0; inst_if.size = 3'd2; inst_if.wdata = '0;
      data_if.req = 1'b1; data_if.cache = 1'b0; data_if.addr = 32'h0000_1000;
      data_if.wr = 1'b0; data_if.wstrb = '0; data_if.size = 3'd2; data_if.wdata = '0;
      mem_if.addr_ok = 1'b1; mem_if.data_ok = 1'b1; mem_if.rdata = '0;

      // ---- reset state: requests and responses present, outputs held off ----
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_mem_req",      mem_if.req,      1'b0);
      check("rst_inst_addr_ok", inst_if.addr_ok, 1'b0);
      check("rst_data_addr_ok", data_if.addr_ok, 1'b0);
      check("rst_inst_data_ok", inst_if.data_ok, 1'b0);
      check("rst_data_data_ok", data_if.data_ok, 1'b0);
      check("rst_resp_err",     resp_err,        1'b0);
      inst_if.req = 1'b0; data_if.req = 1'b0; mem_if.data_ok = 1'b0;
      resetn = 1'b1;
      @(posedge clk); #1;

      // ---- fetch-only stream, accept every cycle, responses 2 cycles later ----
      n_idok = 0;
      inst_if.req = 1'b1; inst_if.addr = 32'hBFC0_0000;
      for (int k = 0; k < 10; k++) begin
         drive_mem();
         step();
         if (acc_i) inst_if.addr += 32'd4;
      end
      drain(5);
      check("inst_stream_responses", n_idok, 10);

      // ---- simultaneous requests: data first, responses steered back ----
      resp_num = 1;
      inst_if.req = 1'b1; inst_if.addr = 32'h0000_2000;
      data_if.req = 1'b1; data_if.addr = 32'h0000_3000; data_if.wr = 1'b0;
      obs_seq = '0;
      cycle();
      cycle();
      drain(5);
      check("sim_order",      obs_seq[1:0], 2'b10);
      check("sim_data_rdata", last_d_rdata, 32'h1111_1111);
      check("sim_inst_rdata", last_i_rdata, 32'h2222_2222);

      // ---- grant lock: fetch held while memory stalls, data waits ----
      aok_pct = 0;
      inst_if.req = 1'b1; inst_if.addr = 32'h0000_4000;
      cycle();
      data_if.req = 1'b1; data_if.addr = 32'h0000_5000; data_if.wr = 1'b1;
      data_if.wstrb = 4'hC; data_if.size = 3'd1; data_if.wdata = 32'hDEAD_BEEF;
      cycle();
      cycle();
      check("hold_addr", mem_if.addr, 32'h0000_4000);
      aok_pct = 100;
      obs_seq = '0;
      cycle();
      cycle();
      check("hold_order", obs_seq[1:0], 2'b01);
      drain(5);

      // ---- full order FIFO blocks the request until a response frees a slot ----
      auto_resp = 1'b0; man_dok = 1'b0;
      inst_if.req = 1'b1; inst_if.addr = 32'h0000_6000;
      for (int k = 0; k < 4; k++) begin
         drive_mem();
         step();
         if (acc_i) inst_if.addr += 32'd4;
      end
      man_dok = 1'b1;
      drive_mem();
      #1 check("full_block", mem_if.req, 1'b0);
      step();
      man_dok = 1'b0;
      drive_mem();
      #1 check("full_resume", mem_if.req, 1'b1);
      step();
      auto_resp = 1'b1;
      drain(8);

      // ---- anti-starvation: fetch wins after four data accepts ----
      lat_min = 1; lat_max = 1; obs_seq = '0;
      inst_if.req = 1'b1; inst_if.addr = 32'h0000_7000;
      data_if.req = 1'b1; data_if.addr = 32'h0000_8000; data_if.wr = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive_mem();
         step();
         if (acc_d) data_if.addr += 32'd4;
         if (acc_i) inst_if.req = 1'b0;
      end
      check("starve_seq", obs_seq, 5'b11110);
      drain(5);

      // ---- randomized traffic ----
      aok_pct = 70; lat_min = 1; lat_max = 6; rand_rdata = 1'b1;
      for (int k = 0; k < 800; k++) begin
         if (!inst_if.req && $urandom_range(2) == 0) begin
            inst_if.req   = 1'b1;
            inst_if.cache = 1'($urandom);
            inst_if.addr  = $urandom & 32'hFFFF_FFFC;
         end
         if (!data_if.req && $urandom_range(2) == 0) begin
            data_if.req   = 1'b1;
            data_if.cache = 1'($urandom);
            data_if.wr    = 1'($urandom);
            data_if.wstrb = 4'($urandom);
            data_if.size  = 3'($urandom_range(2));
            data_if.addr  = $urandom;
            data_if.wdata = $urandom;
         end
         cycle();
      end
      drain(30);

      // ---- asynchronous reset with outstanding transactions ----
      auto_resp = 1'b0; man_dok = 1'b0; aok_pct = 100;
      inst_if.req = 1'b1; inst_if.addr = 32'h0000_9000;
      for (int k = 0; k < 3; k++) begin
         drive_mem();
         step();
         if (acc_i) inst_if.addr += 32'd4;
      end
      drive_mem();
      #2 check("pre_reset_req", mem_if.req, 1'b1);
      resetn = 1'b0;
      #1;
      check("arst_mem_req",      mem_if.req,      1'b0);
      check("arst_inst_addr_ok", inst_if.addr_ok, 1'b0);
      lock = -1; streak = 0; order_q.delete(); due.delete(); m_resp_err = 1'b0;
      inst_if.req = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;
      cyc++;
      man_dok = 1'b1;
      drive_mem();
      step();
      man_dok = 1'b0;
      drive_mem();
      step();
      check("spurious_err", resp_err, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
